multicycle_control_unit: RTL and testbench

//  Multi-cycle RV32I control FSM: fetches via imem handshake, holds instr in IR, decodes opcode class,

---
 rtl/rv32_pkg.sv | 106 ++++++++++
 rtl/opcode_decoder.sv | 25 ++
 rtl/multicycle_control_unit.sv | 138 +++++++++++++
 tb/tb_multicycle_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types for the multi-cycle RV32I control unit: opcodes, instruction classes,
// FSM states and the per-cycle control word with its state/class decode.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_SUB    = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_IFUNCT = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_FAULT
    } mcu_state_t;

    typedef struct packed {
        logic    imem_req;
        logic    dmem_req;
        logic    dmem_we;
        logic    reg_write;
        logic    alu_src;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        alu_op_t alu_op;
        logic    pc_en;
        logic    busy;
        logic    fault;
    } ctrl_t;

    // Moore control word for a state; the class only matters from EXECUTE onwards.
    function automatic ctrl_t ctrl_decode(input mcu_state_t s, input instr_class_t c);
        ctrl_t o;
        o        = '0;
        o.alu_op = ALU_ADD;
        o.busy   = (s != ST_FETCH);
        case (s)
            ST_FETCH: o.imem_req = 1'b1;
            ST_EXECUTE: begin
                case (c)
                    CLS_R: o.alu_op = ALU_RFUNCT;
                    CLS_I_ALU: begin
                        o.alu_src = 1'b1;
                        o.alu_op  = ALU_IFUNCT;
                    end
                    CLS_LOAD, CLS_STORE, CLS_LUI, CLS_AUIPC: o.alu_src = 1'b1;
                    CLS_JAL, CLS_JALR: begin
                        o.alu_src = 1'b1;
                        o.jump    = 1'b1;
                    end
                    CLS_BRANCH: begin
                        o.alu_op = ALU_SUB;
                        o.branch = 1'b1;
                        o.pc_en  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                o.dmem_req = 1'b1;
                o.dmem_we  = (c == CLS_STORE);
            end
            ST_WB: begin
                // jump stays up here because the PC actually loads the target in WB
                o.reg_write  = (c != CLS_ILLEGAL);
                o.mem_to_reg = (c == CLS_LOAD);
                o.jump       = (c == CLS_JAL) || (c == CLS_JALR);
                o.pc_en      = 1'b1;
            end
            ST_FAULT: o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational RV32I major-opcode classifier: IR[6:0] -> instruction class.
module opcode_decoder
    import rv32_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OPC_OP:     instr_class = CLS_R;
            OPC_OP_IMM: instr_class = CLS_I_ALU;
            OPC_LOAD:   instr_class = CLS_LOAD;
            OPC_STORE:  instr_class = CLS_STORE;
            OPC_BRANCH: instr_class = CLS_BRANCH;
            OPC_JAL:    instr_class = CLS_JAL;
            OPC_JALR:   instr_class = CLS_JALR;
            OPC_LUI:    instr_class = CLS_LUI;
            OPC_AUIPC:  instr_class = CLS_AUIPC;
            default:    instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with wait-state memory handshakes, timeout fault and retire counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap to FAULT instead of retiring as a NOP.
module multicycle_control_unit
    import rv32_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic [31:0]      instr,
    output logic             reg_write,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             branch,
    output logic             jump,
    output logic [1:0]       alu_op,
    output logic             pc_en,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam logic [7:0]       TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    mcu_state_t       state_reg, state_next;
    logic [31:0]      ir_reg;
    logic [7:0]       wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] retired_reg;
    ctrl_t            ctrl_reg;
    instr_class_t     ir_class;
    logic             ir_load;
    logic             req_wait;
    logic             store_done;

    opcode_decoder u_opcode_decoder (
        .opcode      (ir_reg[6:0]),
        .instr_class (ir_class)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        ir_load       = 1'b0;
        req_wait      = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_next = ST_DECODE;
                    ir_load    = 1'b1;
                end else begin
                    req_wait = 1'b1;
                end
            end
            ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
                state_next = (ir_class == CLS_ILLEGAL) ? ST_FAULT : ST_EXECUTE;
`else
                state_next = ST_EXECUTE;
`endif
            end
            ST_EXECUTE: begin
                if (ir_class == CLS_LOAD || ir_class == CLS_STORE) begin
                    state_next = ST_MEM;
                end else if (ir_class == CLS_BRANCH) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_next = (ir_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end else begin
                    req_wait = 1'b1;
                end
            end
            ST_WB:    state_next = ST_FETCH;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FETCH;
        endcase

        // A ready arriving on the limit cycle takes the normal path above, so it wins.
        if (req_wait) begin
            if (wait_cnt_reg == TIMEOUT_LAST) begin
                state_next = ST_FAULT;
            end else begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
        end
    end

    // A store retires in the MEM cycle that sees dmem_ready, so this term cannot be registered.
    assign store_done = (state_reg == ST_MEM) && (ir_class == CLS_STORE) && dmem_ready;
    assign pc_en      = ctrl_reg.pc_en | store_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_FETCH;
            ir_reg       <= NOP_INSTR;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
            ctrl_reg     <= ctrl_decode(ST_FETCH, CLS_ILLEGAL);
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            ctrl_reg     <= ctrl_decode(state_next, ir_class);
            if (ir_load) begin
                ir_reg <= imem_rdata;
            end
            if (pc_en) begin
                retired_reg <= retired_reg + CNT_ONE;
            end
        end
    end

    assign imem_req   = ctrl_reg.imem_req;
    assign dmem_req   = ctrl_reg.dmem_req;
    assign dmem_we    = ctrl_reg.dmem_we;
    assign reg_write  = ctrl_reg.reg_write;
    assign alu_src    = ctrl_reg.alu_src;
    assign mem_to_reg = ctrl_reg.mem_to_reg;
    assign branch     = ctrl_reg.branch;
    assign jump       = ctrl_reg.jump;
    assign alu_op     = ctrl_reg.alu_op;
    assign busy       = ctrl_reg.busy;
    assign fault      = ctrl_reg.fault;
    assign instr      = ir_reg;
    assign retired    = retired_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-class vector table plus wait-state,
// timeout, illegal-opcode and mid-operation reset sequences.
module tb_multicycle_control_unit;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_LW    = 32'h0000_A283;
    localparam logic [31:0] I_SW    = 32'h0050_A223;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;
    localparam logic [31:0] I_JALR  = 32'h0000_8067;
    localparam logic [31:0] I_LUI   = 32'h1234_5137;
    localparam logic [31:0] I_AUIPC = 32'h0000_1197;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;
    localparam logic [31:0] I_NOP   = 32'h0000_0013;

    logic        clk;
    // default instance (MEM_TIMEOUT=15)
    logic        rst_n, imem_ready, dmem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req, dmem_req, dmem_we, reg_write, alu_src, mem_to_reg, branch, jump;
    logic [1:0]  alu_op;
    logic        pc_en, busy, fault;
    logic [31:0] instr, retired;
    // short-timeout instance (MEM_TIMEOUT=4)
    logic        rst_n_b, imem_ready_b, dmem_ready_b;
    logic [31:0] imem_rdata_b;
    logic        imem_req_b, dmem_req_b, dmem_we_b, reg_write_b, alu_src_b, mem_to_reg_b, branch_b, jump_b;
    logic [1:0]  alu_op_b;
    logic        pc_en_b, busy_b, fault_b;
    logic [31:0] instr_b, retired_b;

    int checks = 0;
    int errors = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready), .instr(instr),
        .reg_write(reg_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump),
        .alu_op(alu_op), .pc_en(pc_en), .busy(busy), .fault(fault), .retired(retired)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .imem_req(imem_req_b), .imem_ready(imem_ready_b), .imem_rdata(imem_rdata_b),
        .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_ready(dmem_ready_b), .instr(instr_b),
        .reg_write(reg_write_b), .alu_src(alu_src_b), .mem_to_reg(mem_to_reg_b), .branch(branch_b), .jump(jump_b),
        .alu_op(alu_op_b), .pc_en(pc_en_b), .busy(busy_b), .fault(fault_b), .retired(retired_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] code;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic        jump;
        logic        branch;
        int          lat;
        logic        reg_write;
        logic        mem_to_reg;
        logic        dmem_we;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        imem_rdata = I_NOP;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Entered at the first FETCH cycle; leaves at the first FETCH cycle of the next instruction.
    task automatic run_vec(input vec_t v);
        logic [31:0] ret0;
        bit          done;
        ret0 = retired;
        imem_rdata = v.code;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        check({v.name, " fetch imem_req"}, imem_req, 1'b1);
        check({v.name, " fetch busy"}, busy, 1'b0);
        done = 1'b0;
        for (int cyc = 2; cyc <= 8 && !done; cyc++) begin
            step();
            imem_ready = 1'b0;
            if (cyc == 2) begin
                check({v.name, " decode instr"}, instr, v.code);
                check({v.name, " decode strobes"},
                      {reg_write, pc_en, dmem_req, alu_src, branch, jump, imem_req}, 7'b0);
            end
            if (cyc == 3) begin
                check({v.name, " exec alu_src"}, alu_src, v.alu_src);
                check({v.name, " exec alu_op"}, alu_op, v.alu_op);
                check({v.name, " exec jump"}, jump, v.jump);
                check({v.name, " exec branch"}, branch, v.branch);
            end
            if (pc_en === 1'b1) begin
                done = 1'b1;
                check({v.name, " latency"}, cyc, v.lat);
                check({v.name, " retire reg_write"}, reg_write, v.reg_write);
                check({v.name, " retire mem_to_reg"}, mem_to_reg, v.mem_to_reg);
                check({v.name, " retire store req"}, dmem_req & dmem_we, v.dmem_we);
            end
        end
        if (!done) check({v.name, " pc_en seen"}, 0, 1);
        step();
        check({v.name, " retired"}, retired, ret0 + 32'd1);
        check({v.name, " back to fetch"}, imem_req, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{"addi",  I_ADDI,  1'b1, 2'b11, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"add",   I_ADD,   1'b0, 2'b10, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"lw",    I_LW,    1'b1, 2'b00, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{"sw",    I_SW,    1'b1, 2'b00, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{"beq",   I_BEQ,   1'b0, 2'b01, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"jal",   I_JAL,   1'b1, 2'b00, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{"jalr",  I_JALR,  1'b1, 2'b00, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{"lui",   I_LUI,   1'b1, 2'b00, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{"auipc", I_AUIPC, 1'b1, 2'b00, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};

        rst_n_b = 1'b0;
        imem_ready_b = 1'b0;
        dmem_ready_b = 1'b0;
        imem_rdata_b = I_NOP;

        // reset state
        do_reset();
        check("reset imem_req", imem_req, 1'b1);
        check("reset dmem_req", dmem_req, 1'b0);
        check("reset instr", instr, I_NOP);
        check("reset fault", fault, 1'b0);
        check("reset retired", retired, 32'd0);
        check("reset busy", busy, 1'b0);
        check("reset strobes", {pc_en, reg_write, alu_src, mem_to_reg, branch, jump, alu_op}, 8'b0);

        // lw with three data wait cycles
        imem_rdata = I_LW;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        check("lw mem dmem_we", dmem_we, 1'b0);
        n = 0;
        for (int i = 1; i <= 4; i++) begin
            dmem_ready = (i == 4);
            if (dmem_req === 1'b1) n++;
            check("lw mem no pc_en", pc_en, 1'b0);
            step();
        end
        dmem_ready = 1'b0;
        check("lw dmem_req cycles", n, 4);
        check("lw wb dmem_req", dmem_req, 1'b0);
        check("lw wb mem_to_reg", mem_to_reg, 1'b1);
        check("lw wb reg_write", reg_write, 1'b1);
        check("lw wb pc_en", pc_en, 1'b1);
        step();
        check("lw retired", retired, 32'd1);

        // one zero-wait instruction of every class
        for (int i = 0; i < 9; i++) begin
            $display("vector %0d %s instr=%08h", i, vecs[i].name, vecs[i].code);
            run_vec(vecs[i]);
        end
        check("table retired total", retired, 32'd10);

        // fetch ready on the last permitted wait cycle
        do_reset();
        imem_rdata = I_ADDI;
        for (int i = 1; i <= 14; i++) step();
        check("fetch limit pre fault", fault, 1'b0);
        check("fetch limit pre imem_req", imem_req, 1'b1);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        check("fetch limit fault", fault, 1'b0);
        check("fetch limit instr", instr, I_ADDI);
        check("fetch limit busy", busy, 1'b1);
        step();
        step();
        check("fetch limit wb pc_en", pc_en, 1'b1);
        check("fetch limit wb reg_write", reg_write, 1'b1);
        step();
        check("fetch limit retired", retired, 32'd1);

        // fetch ready one cycle too late
        for (int i = 1; i <= 14; i++) step();
        check("fetch late pre fault", fault, 1'b0);
        step();
        check("fetch late fault", fault, 1'b1);
        check("fetch late imem_req", imem_req, 1'b0);
        check("fetch late busy", busy, 1'b1);
        imem_ready = 1'b1;
        step();
        step();
        imem_ready = 1'b0;
        check("fetch late fault sticky", fault, 1'b1);
        check("fetch late reqs", {imem_req, dmem_req, pc_en}, 3'b0);
        check("fetch late retired", retired, 32'd1);

        // illegal opcode
        do_reset();
        imem_rdata = I_ILL;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
`ifdef ILLEGAL_TRAP_EN
        check("illegal trap fault", fault, 1'b1);
        check("illegal trap pc_en", pc_en, 1'b0);
        check("illegal trap retired", retired, 32'd0);
`else
        check("illegal exec pc_en", pc_en, 1'b0);
        check("illegal exec fault", fault, 1'b0);
        step();
        check("illegal wb pc_en", pc_en, 1'b1);
        check("illegal wb reg_write", reg_write, 1'b0);
        step();
        check("illegal retired", retired, 32'd1);
        check("illegal fault", fault, 1'b0);
`endif

        // reset during the MEM cycle of a load
        do_reset();
        imem_rdata = I_LW;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        step();
        step();
        check("midreset in mem", dmem_req, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midreset dmem_req", dmem_req, 1'b0);
        check("midreset imem_req", imem_req, 1'b1);
        check("midreset instr", instr, I_NOP);
        check("midreset retired", retired, 32'd0);
        check("midreset pc_en", pc_en, 1'b0);

        // store timeout on the MEM_TIMEOUT=4 instance
        rst_n_b = 1'b0;
        step();
        rst_n_b = 1'b1;
        imem_rdata_b = I_SW;
        imem_ready_b = 1'b1;
        step();
        imem_ready_b = 1'b0;
        step();
        step();
        check("sw timeout dmem_we", dmem_we_b, 1'b1);
        n = 0;
        for (int i = 0; i < 8 && fault_b !== 1'b1; i++) begin
            if (dmem_req_b === 1'b1) n++;
            step();
        end
        check("sw timeout wait cycles", n, 4);
        check("sw timeout fault", fault_b, 1'b1);
        check("sw timeout busy", busy_b, 1'b1);
        check("sw timeout reqs", {imem_req_b, dmem_req_b}, 2'b0);
        check("sw timeout strobes",
              {pc_en_b, reg_write_b, alu_src_b, mem_to_reg_b, branch_b, jump_b, alu_op_b}, 8'b0);
        check("sw timeout instr", instr_b, I_SW);
        check("sw timeout retired", retired_b, 32'd0);
        repeat (3) step();
        check("sw timeout sticky", {fault_b, imem_req_b, dmem_req_b}, 3'b100);
        rst_n_b = 1'b0;
        step();
        rst_n_b = 1'b1;
        check("sw timeout reset fault", fault_b, 1'b0);
        check("sw timeout reset imem_req", imem_req_b, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
